// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtract cell iterated LSB-first over WIDTH cycles.
// Define SERIAL_SUB_ZERO_FLAG_EN to add the registered zero-result flag output.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Returns {borrow_out, difference} of x - y - c.
    function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic c);
        sub_cell = {(~x & y) | (~(x ^ y) & c), x ^ y ^ c};
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             r_zero;
`endif

    logic [1:0]       w_cell;
    logic             w_d;
    logic             w_nb;
    logic [WIDTH-1:0] w_d_ins;
    logic [WIDTH-1:0] w_d_sr_next;
    logic [1:0]       w_state_next;
    logic             w_last;

    // Bit cell and the difference shift register's next value (d enters at the MSB).
    always_comb begin
        w_cell              = sub_cell(r_a_sr[0], r_b_sr[0], r_c);
        w_d                 = w_cell[0];
        w_nb                = w_cell[1];
        w_d_ins             = {WIDTH{1'b0}};
        w_d_ins[WIDTH-1]    = w_d;
        w_d_sr_next         = (r_d_sr >> 1) | w_d_ins;
        w_last              = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);
    end

    // Next-state decode; start is only looked at in IDLE so it is never queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand/borrow/difference shift datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr <= {WIDTH{1'b0}};
            r_b_sr <= {WIDTH{1'b0}};
            r_d_sr <= {WIDTH{1'b0}};
            r_c    <= 1'b0;
            r_cnt  <= {CW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_d_sr <= {WIDTH{1'b0}};
                        r_c    <= bin;
                        r_cnt  <= {CW{1'b0}};
                    end
                end
                S_SHIFT: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_d_sr <= w_d_sr_next;
                    r_c    <= w_nb;
                    r_cnt  <= r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Status and result registers; results change only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_diff <= {WIDTH{1'b0}};
            r_bout <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            r_zero <= 1'b1;
`endif
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
            if (w_last) begin
                r_diff <= w_d_sr_next;
                r_bout <= w_nb;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                r_zero <= (w_d_sr_next == {WIDTH{1'b0}});
`endif
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign zero = r_zero;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 vector table, multi-cycle corner cases, WIDTH=1 instance.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       rst1 = 1'b1;
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic       zero, zero1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] ediff;
        logic       ebout;
    } vec_t;

    vec_t vecs[8];
    vec_t vecs1[5];
    logic [7:0] exp_prev = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One WIDTH=8 operation; returns cycles from accept edge to the done cycle.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vbin, output int lat);
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; bin = ~vbin;
        check("busy_after_accept", busy, 1);
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin
            if (lat == 4) check("diff_hold_mid_shift", diff, exp_prev);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, cyc, ndone, t1, t2;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0};
        vecs[4] = '{8'h80, 8'h81, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};
        vecs[7] = '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0};

        vecs1[0] = '{8'h00, 8'h01, 1'b0, 8'h01, 1'b1};
        vecs1[1] = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs1[2] = '{8'h01, 8'h01, 1'b1, 8'h01, 1'b1};
        vecs1[3] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs1[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst1_busy", busy1, 0);
        check("rst1_diff", diff1, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check("rst_zero", zero, 1);
`endif
        rst = 1'b0;
        rst1 = 1'b0;

        // Table-driven WIDTH=8 vectors
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat);
            check("latency", lat, 9);
            check("diff", diff, vecs[i].ediff);
            check("bout", bout, vecs[i].ebout);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            check("zero", zero, (vecs[i].ediff == 8'h00));
`endif
            exp_prev = vecs[i].ediff;
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", busy, 0);
            check("diff_held_idle", diff, vecs[i].ediff);
        end

        // Start during SHIFT and during DONE is ignored
        @(negedge clk);
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("ign_latency", cyc, 9);
        check("ign_diff", diff, 8'h23);
        check("ign_bout", bout, 0);
        a = 8'h01; b = 8'h02; bin = 1'b0; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) ndone++;
        end
        check("ign_extra_done", ndone, 0);
        check("ign_busy", busy, 0);
        check("ign_diff_held", diff, 8'h23);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_diff", diff, 0);
        check("arst_bout", bout, 0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check("arst_zero", zero, 1);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("arst_no_done", ndone, 0);
        check("arst_idle", busy, 0);
        exp_prev = 8'h00;
        run8(8'h35, 8'h12, 1'b0, lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_diff", diff, 8'h23);
        check("post_rst_bout", bout, 0);
        @(negedge clk);

        // start held high: back-to-back operations
        @(negedge clk);
        a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h80; b = 8'h81;
        ndone = 0; t1 = 0; t2 = 0;
        for (int c = 1; c <= 26; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = c;
                    check("b2b_diff1", diff, 8'hFE);
                    check("b2b_bout1", bout, 0);
                end else begin
                    t2 = c;
                    start = 1'b0;
                    check("b2b_diff2", diff, 8'hFF);
                    check("b2b_bout2", bout, 1);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 2);
        check("b2b_first_done", t1, 9);
        check("b2b_second_done", t2, 19);

        // WIDTH=1 instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a1 = vecs1[i].va[0]; b1 = vecs1[i].vb[0]; bin1 = vecs1[i].vbin; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            lat = 1;
            while (done1 !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("w1_latency", lat, 2);
            check("w1_diff", diff1, vecs1[i].ediff[0]);
            check("w1_bout", bout1, vecs1[i].ebout);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            check("w1_zero", zero1, (vecs1[i].ediff[0] == 1'b0));
`endif
            @(negedge clk);
            check("w1_done_one_cycle", done1, 0);
            check("w1_idle", busy1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
